// File: rtl/rom_loader.sv
// rom_loader: packs the iosys ROM-loading byte stream into 16-bit little-endian words,
// queues them in a small FIFO and writes them to SDRAM. Optional macro LOADER_CHECKSUM_EN.
module rom_loader #(
  parameter int unsigned       ADDR_W     = 23,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter logic [ADDR_W-1:0] ROM_BASE   = 23'h000000,
  parameter logic [ADDR_W-1:0] SAVE_BASE  = 23'h700000,
  parameter logic [ADDR_W-1:0] BIOS_BASE  = 23'h7C0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [2:0]        loading,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_wstrb,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_size,
  output logic [31:0]       cfg,
  output logic              overflow
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_CFG} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        strb;
  } entry_t;

  state_t            state;
  logic [2:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] byte_cnt;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        low_byte;
  logic              tail_pending;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  entry_t            head;
  entry_t            push_entry;
  logic              push_req;
  logic              push_ok;
  logic              pop;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       csum;
  assign checksum = csum;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr];
  assign pop        = mem_req && mem_ack;
  // Words are addressed from the byte count, so dropped words leave a hole instead of shifting data.
  assign word_addr  = base_addr + {byte_cnt[ADDR_W-1:1], 1'b0};
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok    = push_req && (!fifo_full || pop);
  assign busy       = (state == S_LOAD) || (state == S_FLUSH) || (state == S_DONE) || !fifo_empty;

  // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    push_req        = 1'b0;
    push_entry.addr = word_addr;
    push_entry.data = {din, low_byte};
    push_entry.strb = 2'b11;
    if (state == S_LOAD && loading == mode && din_valid && byte_cnt[0]) begin
      push_req = 1'b1;
    end else if (state == S_FLUSH && tail_pending) begin
      push_req        = 1'b1;
      push_entry.data = {8'h00, low_byte};
      push_entry.strb = 2'b01;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_entry;
  end

  // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // SDRAM write port: one request per FIFO head, held stable until acknowledged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (mem_req) begin
      if (mem_ack) begin
        mem_req  <= 1'b0;
        mem_addr <= mem_addr + ADDR_W'(2);
      end
    end else if (!fifo_empty) begin
      mem_req   <= 1'b1;
      mem_addr  <= head.addr;
      mem_wdata <= head.data;
      mem_wstrb <= head.strb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      mode         <= '0;
      base_addr    <= '0;
      byte_cnt     <= '0;
      low_byte     <= '0;
      tail_pending <= 1'b0;
      done         <= 1'b0;
      rom_size     <= '0;
      cfg          <= '0;
      overflow     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (loading == 3'd1 || loading == 3'd2 || loading == 3'd4) begin
            mode         <= loading;
            byte_cnt     <= '0;
            overflow     <= 1'b0;
            tail_pending <= 1'b0;
            base_addr    <= (loading == 3'd1) ? ROM_BASE :
                            (loading == 3'd2) ? SAVE_BASE : BIOS_BASE;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
            state        <= S_LOAD;
          end else if (loading == 3'd3) begin
            state <= S_CFG;
          end
        end
        S_LOAD: begin
          if (loading != mode) begin
            tail_pending <= byte_cnt[0];
            state        <= S_FLUSH;
          end else if (din_valid) begin
            byte_cnt <= byte_cnt + ADDR_W'(1);
            if (!byte_cnt[0]) low_byte <= din;
            if (byte_cnt[0] && !push_ok) overflow <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            if (push_ok) csum <= csum + 16'(din) + 16'(low_byte);
`endif
          end
        end
        S_FLUSH: begin
          if (tail_pending) begin
            if (push_ok) begin
              tail_pending <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              csum         <= csum + 16'(low_byte);
`endif
            end
          end else if (fifo_empty && !mem_req) begin
            if (mode == 3'd1) rom_size <= byte_cnt;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        S_CFG: begin
          if (loading != 3'd3) state <= S_IDLE;
          else if (din_valid)  cfg   <= {din, cfg[31:8]};
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed and randomized loads against a byte-list model
// of the expected SDRAM write sequence, with a latency-configurable ack responder.
module tb_rom_loader;

  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              resetn;
  logic [2:0]        loading;
  logic [7:0]        din;
  logic              din_valid;
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [1:0]        mem_wstrb;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rom_size;
  logic [31:0]       cfg;
  logic              overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  rom_loader dut (
    .clk       (clk),
    .resetn    (resetn),
    .loading   (loading),
    .din       (din),
    .din_valid (din_valid),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .busy      (busy),
    .done      (done),
    .rom_size  (rom_size),
    .cfg       (cfg),
    .overflow  (overflow)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        strb;
  } wr_t;

  wr_t         wq[$];
  wr_t         exp_q[$];
  logic [7:0]  src[$];
  logic [15:0] exp_sum;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  bit          ack_en = 1'b1;
  int          ack_lat = 3;
  int          drop_lo = 0;
  int          drop_hi = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: records each request once, checks it holds steady, acks after ack_lat cycles.
  initial begin
    bit  seen;
    int  lat;
    wr_t held;
    seen    = 1'b0;
    lat     = 0;
    held    = '0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (!mem_req) begin
        seen = 1'b0;
      end else begin
        if (!seen) begin
          seen = 1'b1;
          lat  = 0;
          held = {mem_addr, mem_wdata, mem_wstrb};
          wq.push_back(held);
        end else begin
          check("hold_stable", 64'({mem_addr, mem_wdata, mem_wstrb}), 64'(held));
        end
        if (ack_en) begin
          lat++;
          if (lat >= ack_lat) begin
            mem_ack = 1'b1;
            seen    = 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] m);
    if (m == 3'd1) return 23'h000000;
    if (m == 3'd2) return 23'h700000;
    return 23'h7C0000;
  endfunction

  // Expected writes: byte pairs from src, little-endian, word w at base+2w; odd tail is low-byte only.
  task automatic model(input logic [ADDR_W-1:0] base);
    int  n;
    wr_t e;
    n       = src.size();
    exp_sum = '0;
    exp_q.delete();
    for (int w = 0; w < (n + 1) / 2; w++) begin
      if (w >= drop_lo && w < drop_hi) continue;
      e.addr = base + ADDR_W'(2 * w);
      if (2 * w + 1 < n) begin
        e.data  = {src[2*w+1], src[2*w]};
        e.strb  = 2'b11;
        exp_sum = exp_sum + 16'(src[2*w]) + 16'(src[2*w+1]);
      end else begin
        e.data  = {8'h00, src[2*w]};
        e.strb  = 2'b01;
        exp_sum = exp_sum + 16'(src[2*w]);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < wq.size()) check($sformatf("%s_w%0d", tag, i), 64'(wq[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic start_load(input logic [2:0] m);
    wq.delete();
    @(negedge clk);
    loading = m;
    @(negedge clk);
  endtask

  // Strobes src[from..to-1]; after every 4-byte burst, idles for gap cycles.
  task automatic send(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      din       = src[i];
      din_valid = 1'b1;
      @(negedge clk);
      if ((i - from) % 4 == 3) begin
        din_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic end_load(input string tag);
    loading = 3'd0;
    wait_idle(tag);
  endtask

  task automatic fill_random(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int               d0;
    int               n;
    logic [2:0]       m;
    logic [ADDR_W-1:0] exp_rom;

    resetn    = 1'b0;
    loading   = 3'd0;
    din       = 8'h00;
    din_valid = 1'b0;
    #23;
    check("rst_mem_req",  64'(mem_req),  64'(0));
    check("rst_outputs",  64'({mem_addr, mem_wdata, mem_wstrb, busy, done, overflow}), 64'(0));
    check("rst_rom_size", 64'(rom_size), 64'(0));
    check("rst_cfg",      64'(cfg),      64'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Mode 1, five bytes, ack three cycles after each request.
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ack_lat = 3;
    d0 = done_cnt;
    start_load(3'd1);
    send(0, 5, 0);
    end_load("m1");
    model(23'h000000);
    compare_writes("m1");
    check("m1_rom_size", 64'(rom_size), 64'(5));
    check("m1_done",     64'(done_cnt - d0), 64'(1));
    check("m1_overflow", 64'(overflow), 64'(0));
    exp_rom = 23'd5;

    // Mode 2, four bytes at the cart-RAM base; rom_size untouched.
    fill_random(4);
    d0 = done_cnt;
    start_load(3'd2);
    send(0, 4, 0);
    end_load("m2");
    model(23'h700000);
    compare_writes("m2");
    check("m2_rom_size", 64'(rom_size), 64'(exp_rom));
    check("m2_done",     64'(done_cnt - d0), 64'(1));

    // Mode 3: config bytes shift into cfg, no writes, no done.
    src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    d0 = done_cnt;
    start_load(3'd3);
    send(0, 5, 0);
    loading = 3'd0;
    repeat (10) @(negedge clk);
    check("cfg_value",  64'(cfg), 64'(32'hEEDDCCBB));
    check("cfg_writes", 64'(wq.size()), 64'(0));
    check("cfg_done",   64'(done_cnt - d0), 64'(0));
    check("cfg_busy",   64'(busy), 64'(0));

    // Unused mode codes are ignored.
    fill_random(4);
    d0 = done_cnt;
    start_load(3'd5);
    send(0, 4, 0);
    repeat (3) @(negedge clk);
    check("m5_busy", 64'(busy), 64'(0));
    loading = 3'd0;
    repeat (10) @(negedge clk);
    check("m5_writes", 64'(wq.size()), 64'(0));
    check("m5_done",   64'(done_cnt - d0), 64'(0));

    // Mode 4 BIOS load with an odd tail.
    src = '{8'hFF, 8'hFF, 8'h02};
    d0 = done_cnt;
    start_load(3'd4);
    send(0, 3, 0);
    end_load("m4");
    model(23'h7C0000);
    compare_writes("m4");
    check("m4_done", 64'(done_cnt - d0), 64'(1));
`ifdef LOADER_CHECKSUM_EN
    check("m4_checksum", 64'(checksum), 64'(16'h0200));
`endif

    // Overflow: acks withheld while 36 bytes stream in; only the first 8 words fit.
    fill_random(40);
    ack_en = 1'b0;
    start_load(3'd1);
    send(0, 36, 0);
    repeat (64) @(negedge clk);
    check("ovf_sticky",  64'(overflow), 64'(1));
    check("ovf_req_held", 64'(mem_req), 64'(1));
    check("ovf_one_req", 64'(wq.size()), 64'(1));
    ack_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wq.size() == 8 && !mem_req) break;
    end
    check("ovf_drain", 64'(wq.size()), 64'(8));
    send(36, 40, 0);
    end_load("ovf");
    drop_lo = 8;
    drop_hi = 18;
    model(23'h000000);
    drop_lo = 0;
    drop_hi = 0;
    compare_writes("ovf");
    check("ovf_rom_size", 64'(rom_size), 64'(40));
    check("ovf_still",    64'(overflow), 64'(1));
    exp_rom = 23'd40;

    // Randomized loads: random mode, length and ack latency; overflow must clear at load start.
    for (int t = 0; t < 5; t++) begin
      case ($urandom_range(0, 2))
        0:       m = 3'd1;
        1:       m = 3'd2;
        default: m = 3'd4;
      endcase
      n       = $urandom_range(1, 30);
      ack_lat = $urandom_range(1, 6);
      fill_random(n);
      d0 = done_cnt;
      start_load(m);
      send(0, n, 20);
      end_load($sformatf("rnd%0d", t));
      model(base_of(m));
      compare_writes($sformatf("rnd%0d", t));
      if (m == 3'd1) exp_rom = ADDR_W'(n);
      check($sformatf("rnd%0d_rom_size", t), 64'(rom_size), 64'(exp_rom));
      check($sformatf("rnd%0d_done", t),     64'(done_cnt - d0), 64'(1));
      check($sformatf("rnd%0d_overflow", t), 64'(overflow), 64'(0));
`ifdef LOADER_CHECKSUM_EN
      check($sformatf("rnd%0d_checksum", t), 64'(checksum), 64'(exp_sum));
`endif
    end

    // Asynchronous reset in the middle of an outstanding request.
    fill_random(6);
    ack_en = 1'b0;
    start_load(3'd1);
    send(0, 6, 0);
    repeat (4) @(negedge clk);
    check("rst_mid_req_before", 64'(mem_req), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_req",  64'(mem_req), 64'(0));
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_size", 64'(rom_size), 64'(0));
    loading = 3'd0;
    ack_en  = 1'b1;
    ack_lat = 2;
    @(negedge clk);
    resetn = 1'b1;
    fill_random(7);
    d0 = done_cnt;
    start_load(3'd1);
    send(0, 7, 0);
    end_load("post_rst");
    model(23'h000000);
    compare_writes("post_rst");
    check("post_rst_rom_size", 64'(rom_size), 64'(7));
    check("post_rst_done",     64'(done_cnt - d0), 64'(1));

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
